// File: rtl/ldtu_encoder_param.sv
// rtl/ldtu_encoder_param.sv - LiTe-DTU sample packer with handshakes, output FIFO and flush.
// Optional LDTU_ENC_IDLE_WORD_EN: present the idle word as valid whenever the FIFO is empty.
module ldtu_encoder_param #(
  parameter int W_BAS         = 6,
  parameter int W_SIG         = 13,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                          CLK_A,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W_SIG-1:0]              in_data,
  input  logic                          in_bflag,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int N_BAS = 30 / W_BAS;
  localparam int BW    = N_BAS * W_BAS;
  localparam int PW    = (N_BAS - 1) * W_BAS;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int IW    = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) + 1 : 1;
  localparam logic [12:0] SYNC = 13'b0101010101010;

  typedef enum logic [1:0] {S_EMPTY, S_BAS, S_SIG1} state_t;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [BW-1:0]   bas_q, bas_d;
  logic [W_SIG-1:0] sig_q, sig_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   idle_q, idle_d;

  logic            room, timeout_hit, flush_req, flush_act, accept, push, pop;
  logic [31:0]     push_data;
  logic [BW-1:0]   bas_ins;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level;

  assign room        = level < (AW+1)'(FIFO_DEPTH);
  assign timeout_hit = (FLUSH_TIMEOUT != 0) && (state_q != S_EMPTY) && !pend_q
                       && (int'(idle_q) == FLUSH_TIMEOUT - 1);
  assign flush_req   = flush | timeout_hit;
  assign flush_act   = (pend_q | flush_req) & room;
  // A flush request in the current cycle already beats a presented sample.
  assign in_ready    = room & ~pend_q & ~flush_req;
  assign accept      = in_valid & in_ready;
  assign bas_ins     = BW'(in_data[W_BAS-1:0]) << (cnt_q * W_BAS);

  always_ff @(posedge CLK_A) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      bas_q   <= '0;
      sig_q   <= '0;
      pend_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bas_q   <= bas_d;
      sig_q   <= sig_d;
      pend_q  <= pend_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bas_d   = bas_q;
    sig_d   = sig_q;
    pend_d  = pend_q | flush_req;
    if (flush_act) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
      bas_d   = '0;
      sig_d   = '0;
      pend_d  = 1'b0;
    end else if (accept) begin
      case (state_q)
        S_EMPTY: begin
          if (in_bflag) begin
            state_d = S_BAS;
            cnt_d   = 6'd1;
            bas_d   = bas_ins;
          end else begin
            state_d = S_SIG1;
            sig_d   = in_data;
          end
        end
        S_BAS: begin
          if (in_bflag && cnt_q == 6'(N_BAS - 1)) begin
            state_d = S_EMPTY;
            cnt_d   = '0;
            bas_d   = '0;
          end else if (in_bflag) begin
            cnt_d   = cnt_q + 6'd1;
            bas_d   = bas_q | bas_ins;
          end else begin
            state_d = S_SIG1;
            cnt_d   = '0;
            bas_d   = '0;
            sig_d   = in_data;
          end
        end
        S_SIG1: begin
          sig_d = '0;
          if (in_bflag) begin
            state_d = S_BAS;
            cnt_d   = 6'd1;
            bas_d   = bas_ins;
          end else begin
            state_d = S_EMPTY;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
    if (accept || state_q == S_EMPTY || flush_req || pend_q || FLUSH_TIMEOUT == 0)
      idle_d = '0;
    else
      idle_d = idle_q + 1'b1;
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (flush_act) begin
      if (state_q == S_BAS) begin
        push      = 1'b1;
        push_data = {2'b10, cnt_q, 24'(bas_q[PW-1:0])};
      end else if (state_q == S_SIG1) begin
        push      = 1'b1;
        push_data = 32'h2C00_0000 | 32'({SYNC[W_SIG-1:0], sig_q});
      end
    end else if (accept) begin
      if (state_q == S_BAS && in_bflag && cnt_q == 6'(N_BAS - 1)) begin
        push      = 1'b1;
        push_data = 32'h4000_0000 | 32'(bas_q | bas_ins);
      end else if (state_q == S_BAS && !in_bflag) begin
        push      = 1'b1;
        push_data = {2'b10, cnt_q, 24'(bas_q[PW-1:0])};
      end else if (state_q == S_SIG1 && in_bflag) begin
        push      = 1'b1;
        push_data = 32'h2C00_0000 | 32'({SYNC[W_SIG-1:0], sig_q});
      end else if (state_q == S_SIG1) begin
        push      = 1'b1;
        push_data = 32'h2800_0000 | 32'({in_data, sig_q});
      end
    end
  end

  assign pop = (level != '0) & out_ready;

  always_ff @(posedge CLK_A) begin
    if (reset && push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK_A) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign out_data   = (level != '0) ? mem[rd_ptr] : 32'hF000_0000;
  assign fifo_level = level;
`ifdef LDTU_ENC_IDLE_WORD_EN
  assign out_valid  = 1'b1;
`else
  assign out_valid  = (level != '0);
`endif

endmodule

// File: tb/tb_ldtu_encoder_param.sv
// tb/tb_ldtu_encoder_param.sv - directed scoreboard bench for ldtu_encoder_param.
module tb_ldtu_encoder_param;

  logic CLK_A = 1'b0;
  always #5 CLK_A = ~CLK_A;

  logic        reset, in_valid, in_ready, in_bflag, flush, out_valid, out_ready;
  logic [12:0] in_data;
  logic [31:0] out_data;
  logic [2:0]  fifo_level;

  logic        in_valid_z, in_ready_z, in_bflag_z, flush_z, out_valid_z, out_ready_z;
  logic [12:0] in_data_z;
  logic [31:0] out_data_z;
  logic [2:0]  fifo_level_z;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef LDTU_ENC_IDLE_WORD_EN
  localparam logic IDLE_VALID = 1'b1;
`else
  localparam logic IDLE_VALID = 1'b0;
`endif

  ldtu_encoder_param dut (
    .CLK_A(CLK_A), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bflag(in_bflag), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level)
  );

  ldtu_encoder_param #(.FLUSH_TIMEOUT(0)) dut_z (
    .CLK_A(CLK_A), .reset(reset), .in_valid(in_valid_z), .in_ready(in_ready_z),
    .in_data(in_data_z), .in_bflag(in_bflag_z), .flush(flush_z), .out_valid(out_valid_z),
    .out_ready(out_ready_z), .out_data(out_data_z), .fifo_level(fifo_level_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] full_bas(input logic [5:0] a, b, c, d, e);
    return {2'b01, e, d, c, b, a};
  endfunction

  // Scoreboard: every word leaving the FIFO must match the oldest expectation.
  always @(negedge CLK_A) begin
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1 && fifo_level != 3'd0) begin
      if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      else chk("word", out_data, exp_q.pop_front());
    end
  end

  task automatic send(input logic [12:0] d, input logic b, input bit push, input logic [31:0] w);
    bit done = 1'b0;
    in_data  = d;
    in_bflag = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (in_ready) begin
        if (push) exp_q.push_back(w);
        done = 1'b1;
        @(posedge CLK_A);
      end
      @(negedge CLK_A);
    end
    if (!done) chk("send_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && fifo_level == 3'd0) break;
      @(negedge CLK_A);
    end
    chk("drain_sb", 32'(exp_q.size()), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    int j;
    reset = 1'b0; in_valid = 1'b0; in_bflag = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    in_valid_z = 1'b0; in_bflag_z = 1'b0; in_data_z = '0; flush_z = 1'b0; out_ready_z = 1'b0;
    repeat (3) @(negedge CLK_A);
    chk("rst_data", out_data, 32'hF000_0000);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'(IDLE_VALID));
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    @(negedge CLK_A);

    // Five baselines make one full word, visible right after the fifth accept.
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) chk("t1_pre_level", 32'(fifo_level), 32'd0);
      send(13'(i), 1'b1, i == 5, full_bas(6'd1, 6'd2, 6'd3, 6'd4, 6'd5));
    end
    chk("t1_latency", 32'(out_valid), 32'd1);
    chk("t1_level", 32'(fifo_level), 32'd1);
    drain();

    send(13'h003F, 1'b1, 1'b0, 32'h0);
    send(13'h0001, 1'b1, 1'b0, 32'h0);
    send(13'h1ABC, 1'b0, 1'b1, 32'h8200_007F);
    send(13'h0123, 1'b0, 1'b1, 32'h2824_7ABC);
    drain();

    // Signal then baseline, then a flush that collides with a new sample.
    send(13'h1FFF, 1'b0, 1'b0, 32'h0);
    send(13'h002A, 1'b1, 1'b1, 32'h2D55_5FFF);
    flush = 1'b1; in_valid = 1'b1; in_data = 13'h0011; in_bflag = 1'b1;
    #1;
    chk("flush_wins", 32'(in_ready), 32'd0);
    exp_q.push_back(32'h8100_002A);
    @(posedge CLK_A);
    @(negedge CLK_A);
    flush = 1'b0; in_valid = 1'b0;
    drain();

    // Back-pressure: four full words fill the FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      logic [5:0] bs;
      bs = 6'(i - 4);
      send(13'(i + 1), 1'b1, (i % 5) == 4,
           full_bas(bs + 6'd1, bs + 6'd2, bs + 6'd3, bs + 6'd4, bs + 6'd5));
    end
    chk("full_level", 32'(fifo_level), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 13'h0021; in_bflag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_stall", 32'(in_ready), 32'd0);
      @(negedge CLK_A);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Timeout flush of a single held baseline.
    send(13'h0015, 1'b1, 1'b1, 32'h8100_0015);
    j = 0;
    while (fifo_level == 3'd0 && j < 40) begin
      @(negedge CLK_A);
      j++;
    end
    chk("timeout_cycles", 32'(j), 32'd16);
    drain();

    // Same sample into the instance with the timeout disabled.
    in_valid_z = 1'b1; in_data_z = 13'h0015; in_bflag_z = 1'b1;
    #1;
    chk("z_ready", 32'(in_ready_z), 32'd1);
    @(posedge CLK_A);
    @(negedge CLK_A);
    in_valid_z = 1'b0;
    repeat (40) @(negedge CLK_A);
    chk("z_no_timeout", 32'(fifo_level_z), 32'd0);
    flush_z = 1'b1;
    @(posedge CLK_A);
    @(negedge CLK_A);
    flush_z = 1'b0;
    chk("z_flush_level", 32'(fifo_level_z), 32'd1);
    chk("z_flush_word", out_data_z, 32'h8100_0015);

    // Reset with three baselines held discards them.
    send(13'h0001, 1'b1, 1'b0, 32'h0);
    send(13'h0002, 1'b1, 1'b0, 32'h0);
    send(13'h0003, 1'b1, 1'b0, 32'h0);
    reset = 1'b0;
    @(posedge CLK_A);
    @(negedge CLK_A);
    chk("mid_rst_data", out_data, 32'hF000_0000);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'(IDLE_VALID));
    reset = 1'b1;
    repeat (30) @(negedge CLK_A);
    chk("post_rst_level", 32'(fifo_level), 32'd0);
    for (int i = 6; i <= 10; i++)
      send(13'(i), 1'b1, i == 10, full_bas(6'd6, 6'd7, 6'd8, 6'd9, 6'd10));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
